// File: rtl/keypad_debounce_encoder.sv
// keypad_debounce_encoder
// Front end for the lock controller. It synchronizes ten raw key lines and
// debounces them. Each accepted press is turned into a 4-bit digit plus a
// one-cycle enter strobe.
// Optional feature macro: KEYPAD_REPEAT_EN. When it is defined, a held key
// re-issues its strobe every REPEAT_CYCLES cycles. When it is undefined, each
// press gives exactly one strobe.
module keypad_debounce_encoder #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] keys,
   output logic [3:0] digit,
   output logic       enter,
   output logic       key_held
);
   localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES) + 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      HELD    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   // True when exactly one key line is active.
   function automatic logic is_single(input logic [9:0] x);
      return (x != 10'd0) && ((x & (x - 10'd1)) == 10'd0);
   endfunction

   // Index of the highest set bit. Callers only use it on single-bit values.
   function automatic logic [3:0] key_index(input logic [9:0] x);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 10; i++) begin
         idx = x[i] ? 4'(i) : idx;
      end
      return idx;
   endfunction

   // One-hot key pattern for an index.
   function automatic logic [9:0] onehot(input logic [3:0] idx);
      return 10'd1 << idx;
   endfunction

   logic [9:0]    s1_r, s2_r;
   state_t        state_r, state_s;
   logic [3:0]    cand_r, cand_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [3:0]    digit_r, digit_s;
   logic          enter_r, enter_s;
   logic          key_held_r, key_held_s;
`ifdef KEYPAD_REPEAT_EN
   localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
   logic [CW-1:0] rcnt_r, rcnt_s;
`endif

   // Two-flop synchronizer; the FSM only ever looks at s2_r.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_r <= 10'd0;
         s2_r <= 10'd0;
      end else begin
         s1_r <= keys;
         s2_r <= s1_r;
      end
   end

   // Debounce FSM next-state logic, plus the strobe and digit capture.
   always_comb begin
      state_s = state_r;
      cand_s  = cand_r;
      cnt_s   = cnt_r;
      digit_s = digit_r;
      enter_s = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rcnt_s  = rcnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (is_single(s2_r)) begin
               cand_s  = key_index(s2_r);
               cnt_s   = CNT_ZERO;
               state_s = PRESS;
            end else begin
               state_s = IDLE;
            end
         end
         PRESS: begin
            if (s2_r == onehot(cand_r)) begin
               if (cnt_r == DEB_LAST) begin
                  digit_s = cand_r;
                  enter_s = 1'b1;
                  state_s = HELD;
`ifdef KEYPAD_REPEAT_EN
                  rcnt_s  = CNT_ZERO;
`endif
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         HELD: begin
            if (s2_r == 10'd0) begin
               cnt_s   = CNT_ZERO;
               state_s = RELEASE;
            end else begin
               state_s = HELD;
`ifdef KEYPAD_REPEAT_EN
               if (s2_r == onehot(digit_r)) begin
                  if (rcnt_r == REP_LAST) begin
                     enter_s = 1'b1;
                     rcnt_s  = CNT_ZERO;
                  end else begin
                     rcnt_s = rcnt_r + CNT_ONE;
                  end
               end else begin
                  rcnt_s = CNT_ZERO;
               end
`endif
            end
         end
         RELEASE: begin
            if (s2_r == 10'd0) begin
               if (cnt_r == DEB_LAST) begin
                  state_s = IDLE;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end else begin
               // A release bounce returns to HELD without a new strobe.
               cnt_s   = CNT_ZERO;
               state_s = HELD;
`ifdef KEYPAD_REPEAT_EN
               rcnt_s  = CNT_ZERO;
`endif
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      key_held_s = (state_s == HELD) || (state_s == RELEASE);
   end

   // FSM state, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         cand_r     <= 4'd0;
         cnt_r      <= CNT_ZERO;
         digit_r    <= 4'd0;
         enter_r    <= 1'b0;
         key_held_r <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rcnt_r     <= CNT_ZERO;
`endif
      end else begin
         state_r    <= state_s;
         cand_r     <= cand_s;
         cnt_r      <= cnt_s;
         digit_r    <= digit_s;
         enter_r    <= enter_s;
         key_held_r <= key_held_s;
`ifdef KEYPAD_REPEAT_EN
         rcnt_r     <= rcnt_s;
`endif
      end
   end

   assign digit    = digit_r;
   assign enter    = enter_r;
   assign key_held = key_held_r;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Testbench for keypad_debounce_encoder.
// Directed reset and latency checks are combined with a randomized stream of
// press events. The expected enter, digit and key_held values for each cycle
// are derived from the event timeline. The bench honours KEYPAD_REPEAT_EN.
module tb_keypad_debounce_encoder;
   localparam int DEB = 4;
   localparam int REP = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] keys;
   logic [3:0] digit;
   logic       enter;
   logic       key_held;

   int errors = 0;
   int checks = 0;

   // Raw stimulus per cycle, plus event records used by the model.
   logic [9:0] stim[$];
   int         acc_t[$];
   int         acc_k[$];
   int         held_lo[$];
   int         held_hi[$];

   keypad_debounce_encoder #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
      .clk(clk), .reset(reset), .keys(keys),
      .digit(digit), .enter(enter), .key_held(key_held)
   );

   // Free-running clock with a 10 ns period.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic push_n(input logic [9:0] v, input int n);
      for (int i = 0; i < n; i++) stim.push_back(v);
   endtask

   // Builds a random event timeline and records where strobes and holds must appear.
   task automatic build_stimulus(input int n_events);
      int kind, key, xk, k2, nb, h, l, len, e0, z0, a, ng;
      bit long_hold, extra;
      logic [9:0] v;
      push_n(10'd0, 6);
      for (int e = 0; e < n_events; e++) begin
         kind = $urandom_range(0, 3);
         key  = $urandom_range(0, 9);
         if (kind == 0) begin
            // Two keys together: never accepted.
            k2 = (key + $urandom_range(1, 9)) % 10;
            len = $urandom_range(1, 20);
            push_n((10'd1 << key) | (10'd1 << k2), len);
            push_n(10'd0, $urandom_range(DEB + 2, DEB + 8));
         end else begin
            nb = $urandom_range(0, 2);
            for (int b = 0; b < nb; b++) begin
               h = $urandom_range(1, DEB);
               l = $urandom_range(1, 3);
               push_n(10'd1 << key, h);
               push_n(10'd0, l);
            end
            long_hold = (kind != 1);
            len = long_hold ? $urandom_range(DEB + 1, DEB + 24) : $urandom_range(1, DEB);
`ifdef KEYPAD_REPEAT_EN
            extra = 1'b0;
            if (long_hold) len = $urandom_range(DEB + 1, 60);
`else
            extra = long_hold && ($urandom_range(0, 1) == 1);
`endif
            xk = (key + $urandom_range(1, 9)) % 10;
            e0 = stim.size();
            for (int i = 0; i < len; i++) begin
               v = 10'd1 << key;
               if (extra && i >= DEB + 2) v = v | (10'd1 << xk);
               stim.push_back(v);
            end
            if (long_hold) begin
               a = e0 + 2 + DEB;
               acc_t.push_back(a);
               acc_k.push_back(key);
`ifdef KEYPAD_REPEAT_EN
               for (int j = 1; a + j * REP <= e0 + len + 1; j++) begin
                  acc_t.push_back(a + j * REP);
                  acc_k.push_back(key);
               end
`else
               ng = $urandom_range(0, 2);
               for (int g = 0; g < ng; g++) begin
                  push_n(10'd0, $urandom_range(1, DEB));
                  push_n(10'd1 << key, 1);
               end
`endif
               z0 = stim.size();
               held_lo.push_back(a);
               held_hi.push_back(z0 + 1 + DEB);
            end
            push_n(10'd0, $urandom_range(DEB + 2, DEB + 8));
         end
      end
   endtask

   // Drives the timeline and compares every cycle against the model.
   task automatic run_stimulus();
      int n, cur;
      bit exp_enter[];
      int exp_key[];
      int exp_digit[];
      bit exp_held[];
      n = stim.size();
      exp_enter = new[n];
      exp_key   = new[n];
      exp_digit = new[n];
      exp_held  = new[n];
      for (int t = 0; t < n; t++) begin
         exp_enter[t] = 1'b0;
         exp_key[t]   = 0;
         exp_held[t]  = 1'b0;
      end
      foreach (acc_t[i]) begin
         exp_enter[acc_t[i]] = 1'b1;
         exp_key[acc_t[i]]   = acc_k[i];
      end
      foreach (held_lo[i]) begin
         for (int t = held_lo[i]; t <= held_hi[i]; t++) exp_held[t] = 1'b1;
      end
      cur = 0;
      for (int t = 0; t < n; t++) begin
         if (exp_enter[t]) cur = exp_key[t];
         exp_digit[t] = cur;
      end
      for (int t = 0; t <= n; t++) begin
         @(negedge clk);
         if (t > 0) begin
            check_eq("rnd_enter", 32'(enter), 32'(exp_enter[t-1]));
            check_eq("rnd_digit", 32'(digit), 32'(exp_digit[t-1]));
            check_eq("rnd_key_held", 32'(key_held), 32'(exp_held[t-1]));
         end
         keys = (t < n) ? stim[t] : 10'd0;
      end
   endtask

   initial begin
      reset = 1'b1;
      keys  = 10'd0;
      repeat (3) @(negedge clk);
      check_eq("rst_digit", 32'(digit), 32'd0);
      check_eq("rst_enter", 32'(enter), 32'd0);
      check_eq("rst_key_held", 32'(key_held), 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Clean press of key 9: the strobe must follow edge E0+6.
      keys = 10'd1 << 9;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_eq("lat9_enter", 32'(enter), (k == 6) ? 32'd1 : 32'd0);
      end
      check_eq("lat9_digit", 32'(digit), 32'd9);
      check_eq("lat9_key_held", 32'(key_held), 32'd1);

      // An asynchronous reset mid-cycle clears the outputs before the next edge.
      keys = 10'd0;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_eq("async_digit", 32'(digit), 32'd0);
      check_eq("async_enter", 32'(enter), 32'd0);
      check_eq("async_key_held", 32'(key_held), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      build_stimulus(40);
      run_stimulus();

      // A reset three cycles into a press discards it; the held key is a new press.
      repeat (2) @(negedge clk);
      keys = 10'd1 << 2;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_eq("midp_enter", 32'(enter), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_eq("midp_strobe", 32'(enter), (k == 6) ? 32'd1 : 32'd0);
      end
      check_eq("midp_digit", 32'(digit), 32'd2);
      check_eq("midp_key_held", 32'(key_held), 32'd1);
      keys = 10'd0;
      repeat (DEB + 4) @(negedge clk);
      check_eq("midp_release", 32'(key_held), 32'd0);
      check_eq("midp_digit_kept", 32'(digit), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/keypad_debounce_encoder.md
Name: keypad_debounce_encoder

Overview:
Upstream front end for the lock controller `top`. It samples ten raw keypad lines (keys 0-9) and synchronizes and debounces them. Each accepted press becomes a 4-bit digit plus a single-cycle enter strobe, matching the lock's digit/enter input contract.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a press or a release (min 2).
REPEAT_CYCLES, 16, hold duration between auto-repeat strobes; used only when KEYPAD_REPEAT_EN is defined.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
keys  input  10  raw, unsynchronized, bouncing key lines; bit i high means key i is pressed.
digit  output  4  last accepted key index, 0-9; feeds lock digit.
enter  output  1  one-cycle strobe on acceptance; feeds lock enter.
key_held  output  1  high while the FSM is in HELD or RELEASE.

Behaviour:
- Reset (async, immediate):
  - sync stages = 0; FSM = IDLE; counters = 0.
  - digit = 0, enter = 0, key_held = 0.
- Synchronizer: two flops on keys (s1, then s2). The FSM sees only s2.
- "single(x)" means x has exactly one bit set; cand is the 4-bit index of that bit.
- Counter cnt: width clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)) + 1.
- FSM states:
  - IDLE:
    - single(s2): cand <= index, cnt <= 0, go to PRESS.
    - Zero or multiple bits set: stay in IDLE.
  - PRESS:
    - s2 == onehot(cand) and cnt == DEBOUNCE_CYCLES-1: digit <= cand, enter <= 1, go to HELD.
    - s2 == onehot(cand), cnt below that: cnt++.
    - Any other s2 (bounce, release, extra key): go to IDLE, no strobe.
  - HELD:
    - s2 == 0: cnt <= 0, go to RELEASE.
    - Otherwise stay. Added or changed keys are ignored; no new strobe until a full release.
  - RELEASE:
    - s2 == 0 and cnt == DEBOUNCE_CYCLES-1: go to IDLE.
    - s2 == 0, cnt below that: cnt++.
    - s2 != 0: cnt <= 0, return to HELD (release bounce does not re-trigger).
- enter:
  - Registered; high exactly one cycle per acceptance.
  - Cleared on every edge where no acceptance occurs.
- digit:
  - Updates only on the edge that sets enter.
  - Otherwise held stable; valid whenever enter is high.
- Latency: let E0 be the first edge where raw key i is sampled high and held clean. enter is high for the cycle following edge E0+2+DEBOUNCE_CYCLES. With default 4, that is edge E0+6.
- Minimum press-to-press spacing:
  - Press held ≥ DEBOUNCE_CYCLES+2 cycles.
  - Release held ≥ DEBOUNCE_CYCLES+2 cycles.
- Reset mid-operation: any pending press is discarded. A key still held after reset deasserts is treated as a new press: sync refills, then a full debounce runs, then one strobe.
- Values ≥10 can never appear on digit.

Optional Feature:
Macro KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a second counter rcnt counts cycles while s2 == onehot(digit).
  - When rcnt == REPEAT_CYCLES-1: enter <= 1 (same digit), rcnt <= 0.
  - Any s2 change resets rcnt to 0.
  - rcnt is cleared on entry to HELD.
- Not defined:
  - rcnt logic is absent.
  - Exactly one strobe per press regardless of hold time.
  - REPEAT_CYCLES is unused.

Test Plan:
1. Reset → assert reset mid-cycle with keys=0 → digit=0, enter=0, key_held=0 immediately, before the next clk edge.
2. Clean press → keys[9]=1 for 20 cycles, then 0 → exactly one enter pulse at edge E0+6, digit=9; key_held falls DEBOUNCE_CYCLES+2 cycles after release.
3. Bounce rejection → keys[7] toggles every 2 cycles for 20 cycles → no enter; digit unchanged. Release bounce of 1-cycle glitches after an accepted press → no second strobe.
4. Multi-key → keys[3] and keys[5] high together for 20 cycles → no enter. Release, then keys[5] alone for 12 cycles → one enter, digit=5.
5. Lock integration → drive the sequence 9, 9, 7, 9 (each press and release 12 cycles) into the encoder feeding top → four single-cycle enter pulses with digit 9, 9, 7, 9; unlocked asserts after the fourth.
6. Reset mid-PRESS, and repeat →
   - Assert reset 3 cycles into a keys[2] press → no strobe. Keep keys[2] held after deassert → one enter with digit=2 at edge 6 after deassert.
   - With KEYPAD_REPEAT_EN, hold keys[4] for 60 cycles → initial strobe plus repeats every 16 cycles, all digit=4.
   - Without the macro, the same hold gives exactly one strobe.
